hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
Parametrised pipeline hazard and stall controller, the successor to the CPU's fixed two-stage hazard logic. Tracks in-flight writers per address space, status flags and the call-address register in shift-register scoreboards of configurable depth. Produces the global stall, branch hazard and decoder reset for the fetch/decode front end. Replaces the hardcoded stage-1/stage-2 select and write inputs with internal tracking.

Parameters:
DEPTH, 2, number of in-flight stages tracked after decode for address-space writers (>=1)
SPACES, 2, number of address spaces tracked (bit 0 = IO, bit 1 = data by convention)
FLAG_DEPTH, 1, stages between decode and status/nzp flag write-back (>=1)
RST_HOLD, 1, extra cycles decoder_rst stays high after rst_n deasserts (0..15)
CNT_W, 16, stall statistics counter width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
issue_valid  in  1  instruction in decode is real (not a bubble)
rd_sel  in  SPACES  decode instruction reads space s
wr_sel  in  SPACES  decode instruction writes/selects space s
flag_wr  in  1  decode instruction updates status/nzp (ALU op other than no-flag op)
ca_wr  in  1  decode instruction writes the call-address register
status_ren  in  1  decode instruction reads status
pc_brx  in  1  decode instruction is conditional branch
pc_jmp  in  1  decode instruction is jump
pc_call  in  1  decode instruction is call
flush_req  in  1  taken branch/jump/call/ret resolved in stage 1
interrupt  in  1  interrupt accepted
cache_miss  in  1  data cache read or write miss
halt  in  1  halt request
stat_clr  in  1  synchronous clear of statistics counters
stall  out  1  freeze fetch/decode, insert bubble
branch_hazard  out  CNT_W? no: 1  branch must wait for flags or call address
decoder_rst  out  1  squash decode stage
cause  out  5  registered cause of previous-cycle stall {halt, miss, branch, status, data}
stall_cycles  out  CNT_W  saturating stall cycle count (optional feature)

Behaviour:
- Scoreboards: pend[s][0..DEPTH-1], fpend[0..FLAG_DEPTH-1], capend[0..DEPTH-1]. Each cycle all shift by one (index 0 = youngest, oldest drops off).
- Shift-in value is decode's wr_sel/flag_wr/ca_wr gated by accept = issue_valid & ~stall & ~decoder_rst. Otherwise a 0 (bubble) enters.
- Registers shift every cycle, including during a stall: the back end keeps draining.
- data_hz = OR over s of (rd_sel[s] & |pend[s]).
- status_hz = status_ren & |fpend.
- br_nzp = pc_brx & |fpend. br_ca = (pc_jmp|pc_call) & |capend. branch_hazard = br_nzp | br_ca.
- Hazard terms are gated by issue_valid. halt and cache_miss are not gated.
- stall = data_hz | status_hz | branch_hazard | cache_miss | halt (combinational, zero latency).
- decoder_rst = flush_req | interrupt | ~rst_n | (hold_cnt != 0).
- hold_cnt is loaded with RST_HOLD during reset and decrements to 0 per cycle after release. Decode is squashed for exactly RST_HOLD cycles post-reset.
- Flush does not clear scoreboards: older instructions are still in flight. The squashed decode instruction is never entered.
- Simultaneous flush and stall: decoder_rst and stall both assert; nothing is entered.
- cause register <= {halt, cache_miss, branch_hazard, status_hz, data_hz} each cycle.
- Reset values: all scoreboards 0, cause 0, stall_cycles 0, hold_cnt RST_HOLD. With inputs idle: stall 0, branch_hazard 0, decoder_rst 1 during reset.
- Reset mid-operation clears all tracking immediately (asynchronous).

Optional Feature:
HAZARD_STATS_EN
- Defined: stall_cycles increments on every cycle with stall=1 and saturates at all-ones. stat_clr wins over increment.
- Undefined: counter logic is omitted, stall_cycles is tied to 0 and stat_clr is ignored.

Test Plan:
- Reset release, RST_HOLD=1 -> decoder_rst high during reset plus exactly 1 cycle after; stall=0, cause=0.
- Issue wr_sel=2'b10, next cycle rd_sel=2'b10 with DEPTH=2 -> stall=1 for 2 cycles, cause=5'b00001 a cycle later; rd_sel=2'b01 instead -> no stall.
- flag_wr issue then pc_brx next cycle (FLAG_DEPTH=1) -> branch_hazard=1 and stall=1 for 1 cycle, then branch proceeds.
- ca_wr then pc_call -> branch_hazard for DEPTH cycles. Add flush_req on the ca_wr cycle -> no entry, no hazard.
- cache_miss held 5 cycles with HAZARD_STATS_EN -> stall_cycles=5. stat_clr with concurrent stall -> 0. Force the counter to all-ones -> it holds.
- rst_n asserted while pend nonzero -> all scoreboards clear, stall drops in the same cycle.

Source files
------------

// File: rtl/hazard_if.sv
// Front-end <-> hazard scoreboard signal bundle: decode-stage descriptors in,
// stall / squash controls and statistics out.
interface hazard_if #(
  parameter int SPACES = 2,
  parameter int CNT_W  = 16
);
  logic              issue_valid;
  logic [SPACES-1:0] rd_sel;
  logic [SPACES-1:0] wr_sel;
  logic              flag_wr;
  logic              ca_wr;
  logic              status_ren;
  logic              pc_brx;
  logic              pc_jmp;
  logic              pc_call;
  logic              flush_req;
  logic              interrupt;
  logic              cache_miss;
  logic              halt;
  logic              stat_clr;
  logic              stall;
  logic              branch_hazard;
  logic              decoder_rst;
  logic [4:0]        cause;
  logic [CNT_W-1:0]  stall_cycles;

  modport master (
    output issue_valid, rd_sel, wr_sel, flag_wr, ca_wr, status_ren,
           pc_brx, pc_jmp, pc_call, flush_req, interrupt, cache_miss,
           halt, stat_clr,
    input  stall, branch_hazard, decoder_rst, cause, stall_cycles
  );

  modport slave (
    input  issue_valid, rd_sel, wr_sel, flag_wr, ca_wr, status_ren,
           pc_brx, pc_jmp, pc_call, flush_req, interrupt, cache_miss,
           halt, stat_clr,
    output stall, branch_hazard, decoder_rst, cause, stall_cycles
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Shift-register hazard scoreboard and stall/squash controller for the fetch/decode front end.
// Optional saturating stall counter enabled by defining HAZARD_STATS_EN.
module hazard_scoreboard #(
  parameter int DEPTH      = 2,
  parameter int SPACES     = 2,
  parameter int FLAG_DEPTH = 1,
  parameter int RST_HOLD   = 1,
  parameter int CNT_W      = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  hazard_if.slave  hz
);

  localparam logic [3:0] HOLD_INIT = 4'(RST_HOLD);

  logic [SPACES-1:0]     pend [DEPTH];
  logic [FLAG_DEPTH-1:0] fpend;
  logic [DEPTH-1:0]      capend;
  logic [3:0]            hold_cnt;
  logic [4:0]            cause_p1;

  logic [SPACES-1:0] pend_any;
  logic              data_hz;
  logic              status_hz;
  logic              br_nzp;
  logic              br_ca;
  logic              br_hz;
  logic              stall_p0;
  logic              dec_rst_p0;
  logic              accept;

  always_comb begin
    pend_any = '0;
    for (int i = 0; i < DEPTH; i++) pend_any = pend_any | pend[i];
  end

  // Decode-stage hazard evaluation (combinational, zero latency)
  assign data_hz    = hz.issue_valid & (|(hz.rd_sel & pend_any));
  assign status_hz  = hz.issue_valid & hz.status_ren & (|fpend);
  assign br_nzp     = hz.issue_valid & hz.pc_brx & (|fpend);
  assign br_ca      = hz.issue_valid & (hz.pc_jmp | hz.pc_call) & (|capend);
  assign br_hz      = br_nzp | br_ca;
  assign stall_p0   = data_hz | status_hz | br_hz | hz.cache_miss | hz.halt;
  assign dec_rst_p0 = hz.flush_req | hz.interrupt | ~rst_n | (hold_cnt != 4'd0);
  assign accept     = hz.issue_valid & ~stall_p0 & ~dec_rst_p0;

  assign hz.stall         = stall_p0;
  assign hz.branch_hazard = br_hz;
  assign hz.decoder_rst   = dec_rst_p0;
  assign hz.cause         = cause_p1;

  // In-flight tracking: shifts every cycle, the back end drains even while decode stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pend[i] <= '0;
      fpend    <= '0;
      capend   <= '0;
      hold_cnt <= HOLD_INIT;
      cause_p1 <= '0;
    end else begin
      pend[0]   <= accept ? hz.wr_sel : '0;
      fpend[0]  <= accept & hz.flag_wr;
      capend[0] <= accept & hz.ca_wr;
      for (int i = 1; i < DEPTH; i++) begin
        pend[i]   <= pend[i-1];
        capend[i] <= capend[i-1];
      end
      for (int i = 1; i < FLAG_DEPTH; i++) fpend[i] <= fpend[i-1];
      if (hold_cnt != 4'd0) hold_cnt <= hold_cnt - 4'd1;
      cause_p1 <= {hz.halt, hz.cache_miss, br_hz, status_hz, data_hz};
    end
  end

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] cnt_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           cnt_p1 <= '0;
    else if (hz.stat_clr) cnt_p1 <= '0;
    else if (stall_p0)    cnt_p1 <= sat_inc(cnt_p1);
  end

  assign hz.stall_cycles = cnt_p1;
`else
  logic unused_stat_clr;
  assign unused_stat_clr = hz.stat_clr;
  assign hz.stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed plus randomized bench for hazard_scoreboard against a cycle-age reference model.
module tb_hazard_scoreboard;
  localparam int DEPTH      = 2;
  localparam int SPACES     = 2;
  localparam int FLAG_DEPTH = 1;
  localparam int RST_HOLD   = 1;
  localparam int CNT_W      = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_if #(.SPACES(SPACES), .CNT_W(CNT_W)) bus ();

  hazard_scoreboard #(
    .DEPTH(DEPTH), .SPACES(SPACES), .FLAG_DEPTH(FLAG_DEPTH),
    .RST_HOLD(RST_HOLD), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hz(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: each writer is remembered by the cycle it was accepted in;
  // it blocks readers for the following DEPTH (or FLAG_DEPTH) cycles.
  int cyc = 0;
  int last_wr [SPACES];
  int last_f, last_ca;
  int hold_left;
  int m_cnt;
  logic [4:0] m_cause;
  logic e_stall, e_br, e_dec, e_data, e_stat;

  task automatic model_clear();
    for (int s = 0; s < SPACES; s++) last_wr[s] = -1000;
    last_f = -1000; last_ca = -1000;
    hold_left = RST_HOLD; m_cnt = 0; m_cause = '0;
  endtask

  function automatic bit live(int t, int d);
    return (cyc - t) <= d;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic idle();
    bus.issue_valid = 0; bus.rd_sel = '0; bus.wr_sel = '0; bus.flag_wr = 0;
    bus.ca_wr = 0; bus.status_ren = 0; bus.pc_brx = 0; bus.pc_jmp = 0;
    bus.pc_call = 0; bus.flush_req = 0; bus.interrupt = 0; bus.cache_miss = 0;
    bus.halt = 0; bus.stat_clr = 0;
  endtask

  task automatic step();
    bit accept;
    @(negedge clk);
    e_data = 0;
    for (int s = 0; s < SPACES; s++)
      if (bus.rd_sel[s] && live(last_wr[s], DEPTH)) e_data = 1;
    e_data = e_data & bus.issue_valid;
    e_stat = bus.issue_valid & bus.status_ren & live(last_f, FLAG_DEPTH);
    e_br   = bus.issue_valid & ((bus.pc_brx & live(last_f, FLAG_DEPTH)) |
                                ((bus.pc_jmp | bus.pc_call) & live(last_ca, DEPTH)));
    e_stall = e_data | e_stat | e_br | bus.cache_miss | bus.halt;
    e_dec   = bus.flush_req | bus.interrupt | !rst_n | (hold_left > 0);
    chk("stall", 32'(bus.stall), 32'(e_stall));
    chk("branch_hazard", 32'(bus.branch_hazard), 32'(e_br));
    chk("decoder_rst", 32'(bus.decoder_rst), 32'(e_dec));
    chk("cause", 32'(bus.cause), 32'(m_cause));
`ifdef HAZARD_STATS_EN
    chk("stall_cycles", 32'(bus.stall_cycles), 32'(m_cnt));
`else
    chk("stall_cycles", 32'(bus.stall_cycles), 32'd0);
`endif
    @(posedge clk);
    if (!rst_n) model_clear();
    else begin
      accept = bus.issue_valid & !e_stall & !e_dec;
      if (accept) begin
        for (int s = 0; s < SPACES; s++) if (bus.wr_sel[s]) last_wr[s] = cyc;
        if (bus.flag_wr) last_f = cyc;
        if (bus.ca_wr) last_ca = cyc;
      end
      m_cause = {bus.halt, bus.cache_miss, e_br, e_stat, e_data};
      if (hold_left > 0) hold_left--;
      if (bus.stat_clr) m_cnt = 0;
      else if (e_stall && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    end
    cyc++;
    #1;
  endtask

  task automatic issue(logic [SPACES-1:0] wr, logic [SPACES-1:0] rd);
    idle(); bus.issue_valid = 1; bus.wr_sel = wr; bus.rd_sel = rd;
  endtask

  initial begin
    idle();
    model_clear();
    rst_n = 0;
    #1;
    // Reset state and release with hold
    step(); step();
    rst_n = 1;
    step(); step(); step();

    // Data-space hazard and independent space
    issue(2'b10, 2'b00); step();
    issue(2'b00, 2'b10); step(); step(); step(); step();
    issue(2'b10, 2'b00); step();
    issue(2'b00, 2'b01); step(); idle(); step(); step();

    // Flag then conditional branch; status read
    idle(); bus.issue_valid = 1; bus.flag_wr = 1; step();
    idle(); bus.issue_valid = 1; bus.pc_brx = 1; step(); step(); step();
    idle(); bus.issue_valid = 1; bus.flag_wr = 1; step();
    idle(); bus.issue_valid = 1; bus.status_ren = 1; step(); step();

    // Call-address hazard, then flushed writer
    idle(); bus.issue_valid = 1; bus.ca_wr = 1; step();
    idle(); bus.issue_valid = 1; bus.pc_call = 1; step(); step(); step(); step();
    idle(); bus.issue_valid = 1; bus.ca_wr = 1; bus.flush_req = 1; step();
    idle(); bus.issue_valid = 1; bus.pc_jmp = 1; step(); step();

    // Cache miss held, stat clear under stall
    idle(); bus.cache_miss = 1;
    repeat (5) step();
    idle(); step();
    bus.halt = 1; bus.stat_clr = 1; step();
    idle(); step();
`ifdef HAZARD_STATS_EN
    bus.halt = 1;
    repeat ((1 << CNT_W) + 3) step();
    idle(); step();
`endif

    // Asynchronous reset with a writer in flight
    issue(2'b01, 2'b00); step();
    issue(2'b00, 2'b01);
    rst_n = 0;
    model_clear();
    step(); step();
    rst_n = 1;
    idle(); step(); step();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      bus.issue_valid = ($urandom_range(0, 9) < 8);
      bus.rd_sel      = SPACES'($urandom);
      bus.wr_sel      = SPACES'($urandom);
      bus.flag_wr     = ($urandom_range(0, 3) == 0);
      bus.ca_wr       = ($urandom_range(0, 5) == 0);
      bus.status_ren  = ($urandom_range(0, 3) == 0);
      bus.pc_brx      = ($urandom_range(0, 4) == 0);
      bus.pc_jmp      = ($urandom_range(0, 7) == 0);
      bus.pc_call     = ($urandom_range(0, 7) == 0);
      bus.flush_req   = ($urandom_range(0, 9) == 0);
      bus.interrupt   = ($urandom_range(0, 29) == 0);
      bus.cache_miss  = ($urandom_range(0, 19) == 0);
      bus.halt        = ($urandom_range(0, 29) == 0);
      bus.stat_clr    = ($urandom_range(0, 39) == 0);
      if (n == 300) begin
        rst_n = 0;
        model_clear();
      end
      if (n == 303) rst_n = 1;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
